// File: rtl/riscv_arb_pkg.sv
// Shared types for the IF/DM memory port arbiter.
package riscv_arb_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_IF,
    OWNER_DM
  } owner_e;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_e;

endpackage

// File: rtl/arb_priority_select.sv
// Combinational winner choice: a held lock wins outright, then a starving IF, then DM over IF.
module arb_priority_select
  import riscv_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   dm_req,
  input  logic   lock,
  input  owner_e lock_owner,
  input  logic   starve,
  output owner_e winner
);

  always_comb begin
    winner = OWNER_NONE;
    if (lock)
      winner = lock_owner;
    else if (if_req && (starve || !dm_req))
      winner = OWNER_IF;
    else if (dm_req)
      winner = OWNER_DM;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (DM), one transaction outstanding.
// Define RISCV_ARB_STARVE_GUARD_EN to let IF win after MaxWait consecutive DM wins.
module mem_port_arbiter
  import riscv_arb_pkg::*;
#(
  parameter int RegBits = 32,
  parameter int MaxWait = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               if_req_i,
  input  logic [RegBits-1:0] if_addr_i,
  output logic               if_gnt_o,
  output logic               if_rvalid_o,
  output logic [RegBits-1:0] if_rdata_o,
  input  logic               dm_req_i,
  input  logic               dm_we_i,
  input  logic [RegBits-1:0] dm_addr_i,
  input  logic [RegBits-1:0] dm_wdata_i,
  output logic               dm_gnt_o,
  output logic               dm_rvalid_o,
  output logic [RegBits-1:0] dm_rdata_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [RegBits-1:0] mem_addr_o,
  output logic [RegBits-1:0] mem_wdata_o,
  input  logic               mem_gnt_i,
  input  logic               mem_rvalid_i,
  input  logic [RegBits-1:0] mem_rdata_i
);

  if (MaxWait < 1) begin : g_bad_maxwait
    $error("MaxWait must be at least 1");
  end

  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d;
  owner_e     lock_owner_q, lock_owner_d;
  logic       lock_q, lock_d;
  owner_e     winner, active;
  logic       arb_en, starve;

  // Arbitration also runs in the response cycle so a waiting request can go back-to-back.
  assign arb_en = (state_q == IDLE) || mem_rvalid_i;
  assign active = arb_en ? winner : OWNER_NONE;

  arb_priority_select u_sel (
    .if_req     (if_req_i),
    .dm_req     (dm_req_i),
    .lock       (lock_q),
    .lock_owner (lock_owner_q),
    .starve     (starve),
    .winner     (winner)
  );

`ifdef RISCV_ARB_STARVE_GUARD_EN
  localparam int CntW = $clog2(MaxWait + 1);
  logic [CntW-1:0] starve_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || !if_req_i || if_gnt_o)
      starve_cnt_q <= '0;
    else if (dm_gnt_o && starve_cnt_q != CntW'(MaxWait))
      starve_cnt_q <= starve_cnt_q + CntW'(1);
  end

  assign starve = (starve_cnt_q == CntW'(MaxWait));
`else
  assign starve = 1'b0;
`endif

  always_comb begin
    mem_req_o   = (active != OWNER_NONE);
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if_gnt_o    = (active == OWNER_IF) && mem_gnt_i;
    dm_gnt_o    = (active == OWNER_DM) && mem_gnt_i;
    if_rvalid_o = (state_q == BUSY) && mem_rvalid_i && (owner_q == OWNER_IF);
    dm_rvalid_o = (state_q == BUSY) && mem_rvalid_i && (owner_q == OWNER_DM);
    if_rdata_o  = mem_rdata_i;
    dm_rdata_o  = mem_rdata_i;
    if (active == OWNER_IF) begin
      mem_addr_o = if_addr_i;
    end else if (active == OWNER_DM) begin
      mem_we_o    = dm_we_i;
      mem_addr_o  = dm_addr_i;
      mem_wdata_o = dm_wdata_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    if (state_q == BUSY && mem_rvalid_i) begin
      state_d = IDLE;
      owner_d = OWNER_NONE;
    end
    if (active != OWNER_NONE) begin
      if (mem_gnt_i) begin
        state_d      = BUSY;
        owner_d      = active;
        lock_d       = 1'b0;
        lock_owner_d = OWNER_NONE;
      end else begin
        lock_d       = 1'b1;
        lock_owner_d = active;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_NONE;
      lock_q       <= 1'b0;
      lock_owner_q <= OWNER_NONE;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a response-owner scoreboard.
module tb_mem_port_arbiter;
  import riscv_arb_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         if_req_i, dm_req_i, dm_we_i;
  logic [W-1:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
  logic         mem_gnt_i, mem_rvalid_i;
  logic         if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o;
  logic         mem_req_o, mem_we_o;
  logic [W-1:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;

  int     errors = 0;
  int     checks = 0;
  owner_e exp_q[$];
  bit     guard;
  bit     exp_if;

  always #5 clk = ~clk;

  mem_port_arbiter #(.RegBits(W), .MaxWait(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_gnt_o     (if_gnt_o),
    .if_rvalid_o  (if_rvalid_o),
    .if_rdata_o   (if_rdata_o),
    .dm_req_i     (dm_req_i),
    .dm_we_i      (dm_we_i),
    .dm_addr_i    (dm_addr_i),
    .dm_wdata_i   (dm_wdata_i),
    .dm_gnt_o     (dm_gnt_o),
    .dm_rvalid_o  (dm_rvalid_o),
    .dm_rdata_o   (dm_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Pops the expected owner of the response now on mem_rvalid_i.
  task automatic chk_resp(input string tag, input logic [W-1:0] data);
    owner_e e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : OWNER_NONE;
    chk({tag, ".if_rvalid"}, if_rvalid_o, e == OWNER_IF);
    chk({tag, ".dm_rvalid"}, dm_rvalid_o, e == OWNER_DM);
    if (e == OWNER_IF) chk({tag, ".if_rdata"}, if_rdata_o, data);
    if (e == OWNER_DM) chk({tag, ".dm_rdata"}, dm_rdata_o, data);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".mem_req"}, mem_req_o, 0);
    chk({tag, ".mem_we"}, mem_we_o, 0);
    chk({tag, ".mem_addr"}, mem_addr_o, 0);
    chk({tag, ".mem_wdata"}, mem_wdata_o, 0);
    chk({tag, ".if_gnt"}, if_gnt_o, 0);
    chk({tag, ".dm_gnt"}, dm_gnt_o, 0);
    chk({tag, ".if_rvalid"}, if_rvalid_o, 0);
    chk({tag, ".dm_rvalid"}, dm_rvalid_o, 0);
  endtask

  initial begin
`ifdef RISCV_ARB_STARVE_GUARD_EN
    guard = 1'b1;
`else
    guard = 1'b0;
`endif
    rst_i = 1'b1; if_req_i = 0; dm_req_i = 0; dm_we_i = 0;
    if_addr_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    nxt(); smp();
    chk_idle_outputs("reset");

    // IF-only fetch
    nxt(); rst_i = 0; if_req_i = 1; if_addr_i = 32'h10; mem_gnt_i = 1;
    smp();
    chk("if_only.mem_req", mem_req_o, 1);
    chk("if_only.addr", mem_addr_o, 32'h10);
    chk("if_only.if_gnt", if_gnt_o, 1);
    chk("if_only.we", mem_we_o, 0);
    exp_q.push_back(OWNER_IF);
    nxt(); if_req_i = 0; mem_gnt_i = 0;
    smp(); chk("if_only.busy_req", mem_req_o, 0);
    nxt(); mem_rvalid_i = 1; mem_rdata_i = 32'h00500093;
    smp(); chk_resp("if_only.resp", 32'h00500093);

    // Simultaneous: DM first, IF after
    nxt(); mem_rvalid_i = 0; if_req_i = 1; if_addr_i = 32'h20;
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h100; mem_gnt_i = 1;
    smp();
    chk("simul.addr", mem_addr_o, 32'h100);
    chk("simul.dm_gnt", dm_gnt_o, 1);
    chk("simul.if_gnt", if_gnt_o, 0);
    exp_q.push_back(OWNER_DM);
    nxt(); dm_req_i = 0; mem_gnt_i = 0;
    smp(); chk("simul.busy_req", mem_req_o, 0);
    nxt(); mem_rvalid_i = 1; mem_rdata_i = 32'h1234;
    smp(); chk_resp("simul.dm_resp", 32'h1234);
    chk("simul.b2b_addr", mem_addr_o, 32'h20);
    nxt(); mem_rvalid_i = 0; mem_gnt_i = 1;
    smp();
    chk("simul.if_gnt2", if_gnt_o, 1);
    chk("simul.addr2", mem_addr_o, 32'h20);
    exp_q.push_back(OWNER_IF);
    nxt(); if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hAAAA5555;
    smp(); chk_resp("simul.if_resp", 32'hAAAA5555);

    // Lock: IF held without grant while DM rises
    nxt(); mem_rvalid_i = 0; if_req_i = 1; if_addr_i = 32'h30; mem_gnt_i = 0;
    smp();
    chk("lock.c1_addr", mem_addr_o, 32'h30);
    chk("lock.c1_if_gnt", if_gnt_o, 0);
    nxt(); dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h200; dm_wdata_i = 32'hDEADBEEF;
    smp();
    chk("lock.c2_addr", mem_addr_o, 32'h30);
    chk("lock.c2_we", mem_we_o, 0);
    chk("lock.c2_dm_gnt", dm_gnt_o, 0);
    nxt(); smp();
    chk("lock.c3_addr", mem_addr_o, 32'h30);
    nxt(); mem_gnt_i = 1;
    smp();
    chk("lock.gnt_if", if_gnt_o, 1);
    chk("lock.gnt_dm", dm_gnt_o, 0);
    chk("lock.gnt_addr", mem_addr_o, 32'h30);
    exp_q.push_back(OWNER_IF);
    nxt(); if_req_i = 0; mem_gnt_i = 0;
    smp(); chk("lock.busy_req", mem_req_o, 0);

    // IF response with DM store granted back-to-back
    nxt(); mem_rvalid_i = 1; mem_rdata_i = 32'h13; mem_gnt_i = 1;
    smp();
    chk_resp("store.if_resp", 32'h13);
    chk("store.dm_gnt", dm_gnt_o, 1);
    chk("store.we", mem_we_o, 1);
    chk("store.addr", mem_addr_o, 32'h200);
    chk("store.wdata", mem_wdata_o, 32'hDEADBEEF);
    exp_q.push_back(OWNER_DM);
    nxt(); dm_req_i = 0; dm_we_i = 0; mem_rvalid_i = 0; mem_gnt_i = 0;
    if_req_i = 1; if_addr_i = 32'h40;
    smp();
    chk("store.busy_req", mem_req_o, 0);
    chk("store.busy_if_gnt", if_gnt_o, 0);
    nxt(); mem_rvalid_i = 1; mem_rdata_i = 32'h0; mem_gnt_i = 1;
    smp();
    chk_resp("store.ack", 32'h0);
    chk("store.b2b_if_gnt", if_gnt_o, 1);
    chk("store.b2b_addr", mem_addr_o, 32'h40);
    chk("store.b2b_we", mem_we_o, 0);
    exp_q.push_back(OWNER_IF);

    // Reset with IF transaction outstanding, then a stale response
    nxt(); if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; rst_i = 1;
    nxt(); rst_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h99;
    exp_q.delete();
    smp(); chk_idle_outputs("rst_busy");

    // Continuous DM traffic with IF pending
    nxt(); mem_rvalid_i = 0; if_req_i = 1; if_addr_i = 32'h50;
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h400; mem_gnt_i = 1;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) begin
        nxt(); mem_rvalid_i = 1; mem_rdata_i = 32'(k);
      end
      smp();
      if (k > 1) chk_resp($sformatf("starve%0d.resp", k), 32'(k));
      exp_if = guard && (k == 5);
      chk($sformatf("starve%0d.if_gnt", k), if_gnt_o, exp_if);
      chk($sformatf("starve%0d.dm_gnt", k), dm_gnt_o, !exp_if);
      exp_q.push_back(exp_if ? OWNER_IF : OWNER_DM);
    end
    nxt(); if_req_i = 0; dm_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE;
    smp();
    chk_resp("starve.last", 32'hCAFE);
    chk("starve.last_req", mem_req_o, 0);
    nxt(); mem_rvalid_i = 0;
    smp(); chk("end.mem_req", mem_req_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between two requesters: the instruction-fetch path (IF) and the load/store path (DM) of the RISC-V core.
- Arbitrates requests, forwards the winning request to memory, and routes each response back to its owner.
- Allows one outstanding transaction at a time.
- Sits between the core (program_counter/instruction fetch, ALU address/store data) and the single memory macro. The losing requester stalls.

Parameters:
RegBits, 32, address/data width
MaxWait, 4, consecutive lost IF arbitrations before IF is forced to win (used only with optional feature)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
if_req_i  in  1  fetch request; held with if_addr_i stable until if_gnt_o
if_addr_i  in  RegBits  fetch address
if_gnt_o  out  1  fetch request accepted this cycle
if_rvalid_o  out  1  fetch response valid (one-cycle pulse)
if_rdata_o  out  RegBits  fetch data
dm_req_i  in  1  data request; held with addr/we/wdata stable until dm_gnt_o
dm_we_i  in  1  1 = store, 0 = load
dm_addr_i  in  RegBits  data address
dm_wdata_i  in  RegBits  store data
dm_gnt_o  out  1  data request accepted this cycle
dm_rvalid_o  out  1  data response valid (load data or store ack)
dm_rdata_o  out  RegBits  load data
mem_req_o  out  1  request to memory
mem_we_o  out  1  write enable to memory
mem_addr_o  out  RegBits  memory address
mem_wdata_o  out  RegBits  memory write data
mem_gnt_i  in  1  memory accepts request this cycle
mem_rvalid_i  in  1  memory response; exactly one per accepted request, reads and writes
mem_rdata_i  in  RegBits  memory read data

Behaviour:
- One clock (clk_i). Reset rst_i is synchronous and active-high.
- Reset values:
  - state IDLE, owner NONE, lock clear, starvation counter 0.
  - All gnt, rvalid and mem_req_o outputs 0.
  - mem_we_o 0. mem_addr_o and mem_wdata_o 0 while mem_req_o is low.
- States:
  - IDLE: no outstanding transaction.
  - BUSY: transaction outstanding, owner recorded.
- Arbitration is evaluated in IDLE, and also in a BUSY cycle with mem_rvalid_i=1, to allow back-to-back transactions.
- Priority: DM wins over IF (DM belongs to the older instruction).
- The winner's fields drive mem_* combinationally, with mem_req_o=1.
- If mem_gnt_i=1 in the same cycle:
  - The winner's gnt_o is asserted combinationally in that cycle (zero-cycle grant latency).
  - Owner is latched and the next state is BUSY.
- If mem_gnt_i=0:
  - The selection is locked, so mem_* stay on the same requester even if the other requester raises req.
  - The lock holds until mem_gnt_i, then clears.
- BUSY:
  - mem_req_o=0 unless the back-to-back case above applies.
  - On mem_rvalid_i, the owner's rvalid_o pulses in that same cycle (combinational pass-through).
  - Next state is IDLE, or BUSY if a new grant occurs in the same cycle.
- if_rdata_o and dm_rdata_o are always equal to mem_rdata_i; they are meaningful only while the matching rvalid_o is high.
- mem_rvalid_i while in IDLE (e.g. a response for a transaction cut off by reset) is ignored: no rvalid_o pulses.
- Reset mid-transaction: the outstanding response is dropped and any held lock is cleared.
- Both requests deasserted: mem_req_o=0 and the state is unchanged.

Optional Feature:
- Macro: RISCV_ARB_STARVE_GUARD_EN.
- Defined:
  - Counter of consecutive cycles in which if_req_i=1 and DM wins an arbitration.
  - Width is $clog2(MaxWait+1); the counter saturates at MaxWait.
  - When counter == MaxWait, IF wins the next unlocked arbitration over DM.
  - The counter clears on if_gnt_o or when if_req_i=0.
- Undefined: strict DM priority, and no counter logic is present.

Decomposition:
- Package riscv_arb_pkg holds:
  - owner_e enum: OWNER_NONE, OWNER_IF, OWNER_DM.
  - arb_state_e enum: IDLE, BUSY.
- Sub-module arb_priority_select: combinational winner choice from req bits, lock, and starve flag. Everything else lives in mem_port_arbiter.

Test Plan:
- IF-only: if_req_i=1 with addr 0x10, mem_gnt_i=1 → if_gnt_o=1 in the same cycle. Two cycles later mem_rvalid_i=1 with rdata 0x00500093 → if_rvalid_o=1 and if_rdata_o=0x00500093; dm_rvalid_o stays 0.
- Simultaneous requests: if addr 0x20 and dm load at addr 0x100 in the same cycle → mem_addr_o=0x100 and dm_gnt_o=1; after the DM response, IF is granted with mem_addr_o=0x20.
- Lock: IF presented with mem_gnt_i=0 for 3 cycles and dm_req_i rising in cycle 2 → mem_addr_o stays at the IF address until mem_gnt_i; then if_gnt_o is asserted.
- Back-to-back store: in the cycle mem_rvalid_i acks a DM store of 0xDEADBEEF to 0x200, a waiting IF request is granted in that same cycle; mem_we_o=0 for the IF request.
- Reset mid-BUSY: rst_i=1 for 1 cycle, then a late mem_rvalid_i → no rvalid_o pulse, and all outputs at reset values.
- Starvation (macro defined, MaxWait=4): DM requests continuously with IF pending → IF is granted at the 5th arbitration. Without the macro, IF is never granted while DM requests.
